keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives the rows of a 4x4 matrix keypad and reads back its columns, the
//  driving end of the keypad interface. Scans one active-low row at a time and
//  debounces a detected press. Emits exactly one key_valid pulse with a hex
//  key_code per debounced press, then waits for a debounced release.
// PARAMETERS
//  SCAN_DIVIDER      22'd50000   clk cycles each row stays driven while scanning
//  DEBOUNCE_DIVIDER  22'd200000  consecutive stable cycles needed to accept press or release
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-low reset
//  cols       in   4   keypad columns, active-low, pulled up, asynchronous to clk
//  rows       out  4   keypad rows, one-hot active-low
//  key_code   out  4   hex code of last accepted key, held until next accept
//  key_valid  out  1   1-cycle pulse when key_code updates
//  key_held   out  1   high from accept until release is debounced
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=SCAN, row_idx=0, rows=4'b1110,
//    key_code=0, key_valid=0, key_held=0, both counters=0, sync flops=4'hF.
//  - cols pass through a 2-flop synchronizer (colsync); all decisions use colsync.
//    Press-to-detect latency therefore includes 2 cycles of synchronizer delay.
//  - rows = ~(4'b1 << row_idx) at all times; row_idx changes only in SCAN.
//  - SCAN: scan_cnt counts 0..SCAN_DIVIDER-1. At terminal count:
//      colsync==4'hF -> row_idx+=1 (3 wraps to 0), scan_cnt=0.
//      else -> latch row_idx and col_idx = lowest index with colsync bit 0.
//              Go to DEBOUNCE with deb_cnt=0.
//  - DEBOUNCE: each cycle colsync[col_idx]==0 -> deb_cnt+=1.
//      colsync[col_idx]==1 -> back to SCAN, row_idx+=1, scan_cnt=0, no pulse.
//      When deb_cnt reaches DEBOUNCE_DIVIDER-1 and the bit is still low:
//        key_code=KEYMAP(row,col) and key_valid=1 for that single cycle.
//        key_held=1, go to HELD.
//  - HELD: row frozen. colsync[col_idx]==1 -> go to RELEASE with deb_cnt=0.
//  - RELEASE: colsync[col_idx]==1 each cycle -> deb_cnt+=1.
//      Bit low again -> back to HELD, no new pulse (release bounce).
//      deb_cnt reaches DEBOUNCE_DIVIDER-1 -> key_held=0, row_idx+=1, scan_cnt=0, SCAN.
//  - Multiple keys: the lowest column in the lowest scanned row wins.
//    Other keys pressed while in DEBOUNCE/HELD/RELEASE are ignored.
//    They are not reported after release unless still down at the next scan.
//  - Counters are 22 bits and never wrap; the only exits are the state
//    transitions above.
//  - Reset mid-operation (any state) returns to the reset values next cycle.
//    A pending key_valid is dropped.
//  - KEYMAP rows 0..3: {1,2,3,A} {4,5,6,B} {7,8,9,C} {E,0,F,D}. Columns run 0..3.
// STRUCTURE
//  - keypad_pkg: state_t enum {SCAN,DEBOUNCE,HELD,RELEASE}.
//    keypad_pkg: function keymap(row,col) -> logic[3:0].
//    keypad_pkg: localparams for the row/col width (4).
//  - Sub-module sync2: 2-flop synchronizer for 4 bits, reset value 4'hF.
//  - Top module: one FSM plus scan_cnt and deb_cnt.
// TESTING (SCAN_DIVIDER=4, DEBOUNCE_DIVIDER=100, 10-unit clk)
//  1 Reset: hold reset=0 for 3 cycles -> rows=1110, key_code=0.
//    Also key_valid=0 and key_held=0.
//  2 Scan walk, no keys: cols=F -> rows steps 1110,1101,1011,0111,1110, 4 cycles per row.
//  3 Key '5' (row1,col1) held 150 cycles, then released -> exactly one key_valid pulse.
//    That pulse shows key_code=4'h5. key_held=1 until 100 cycles after release.
//  4 Bouncy '9': cols[2] toggles every 15 units for 60 units while row2 is driven.
//    Then stays low -> no pulse during bounce. One pulse with key_code=9 after 100 stable cycles.
//  5 Release bounce while holding 'D': toggle the bit 3x within 50 cycles, then release.
//    -> no second pulse, key_held stays 1 until 100 stable-high cycles.
//  6 Two keys: '1' and '3' both down in row0 -> key_code=1.
//    Then reset=0 mid-HELD -> key_held=0 and rows=1110 on the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, widths and key decoding for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned KEY_W = 4;   // row / column / key code width
    localparam int unsigned IDX_W = 2;   // row and column index width
    localparam int unsigned CNT_W = 22;  // scan and debounce counter width

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Hex code printed on the key at (row, col).
    function automatic logic [KEY_W-1:0] keymap(input logic [IDX_W-1:0] row,
                                                input logic [IDX_W-1:0] col);
        logic [KEY_W-1:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    // Index of the lowest active-low (zero) column.
    function automatic logic [IDX_W-1:0] lowest_low(input logic [KEY_W-1:0] c);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(KEY_W) - 1; i >= 0; i--) begin
            if (!c[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad columns.
module keypad_scanner_sync2
    import keypad_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] d,
    output logic [KEY_W-1:0] q
);

    logic [KEY_W-1:0] meta;

    // Idle value is all-high so a reset never looks like a key press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and one pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter logic [CNT_W-1:0] SCAN_DIVIDER     = 22'd50000,
    parameter logic [CNT_W-1:0] DEBOUNCE_DIVIDER = 22'd200000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] cols,
    output logic [KEY_W-1:0] rows,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    logic [KEY_W-1:0] colsync;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] scan_cnt, scan_d;
    logic [CNT_W-1:0] deb_cnt, deb_d;
    logic [KEY_W-1:0] code_d;
    logic             valid_d;
    logic             held_d;
    logic             key_low;

    keypad_scanner_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (colsync)
    );

    assign key_low = ~colsync[col_q];

    // Next-state and output decode for scan, debounce, hold and release.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        scan_d  = scan_cnt;
        deb_d   = deb_cnt;
        code_d  = key_code;
        valid_d = 1'b0;
        held_d  = key_held;
        case (state_q)
            SCAN: begin
                if (scan_cnt == SCAN_DIVIDER - 22'd1) begin
                    scan_d = '0;
                    if (colsync == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d   = lowest_low(colsync);
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end else begin
                    scan_d = scan_cnt + 22'd1;
                end
            end
            DEBOUNCE: begin
                if (!key_low) begin
                    row_d   = row_q + 2'd1;
                    scan_d  = '0;
                    state_d = SCAN;
                end else if (deb_cnt == DEBOUNCE_DIVIDER - 22'd1) begin
                    code_d  = keymap(row_q, col_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    deb_d = deb_cnt + 22'd1;
                end
            end
            HELD: begin
                if (!key_low) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (key_low) begin
                    state_d = HELD;
                end else if (deb_cnt == DEBOUNCE_DIVIDER - 22'd1) begin
                    held_d  = 1'b0;
                    row_d   = row_q + 2'd1;
                    scan_d  = '0;
                    state_d = SCAN;
                end else begin
                    deb_d = deb_cnt + 22'd1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // State, counters and registered outputs; rows track the next row index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SCAN;
            row_q     <= '0;
            col_q     <= '0;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            rows      <= 4'b1110;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            scan_cnt  <= scan_d;
            deb_cnt   <= deb_d;
            rows      <= ~(KEY_W'(1) << row_d);
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against a keypad model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] key_down;   // bit r*4+c is set while key (r,c) is physically down
    int          checks = 0;
    int          errors = 0;
    int          pulse_cnt = 0;
    logic [3:0]  last_code = 4'h0;
    time         pulse_time = 0;

    // Printed legend of the keypad, row-major.
    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(
        .SCAN_DIVIDER     (22'd4),
        .DEBOUNCE_DIVIDER (22'd100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low when its row is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && key_down[r*4+c]) cols[c] = 1'b0;
    end

    // Pulse monitor, sampled mid-cycle after each active edge.
    always @(posedge clk) begin
        #2;
        if (key_valid === 1'b1) begin
            pulse_cnt  = pulse_cnt + 1;
            last_code  = key_code;
            pulse_time = $time;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_pulse(input int target, input int max_cyc);
        int n = 0;
        while (pulse_cnt < target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", 32'(pulse_cnt >= target), 32'd1);
    endtask

    task automatic wait_rows(input logic [3:0] want, input int max_cyc);
        int n = 0;
        while (rows !== want && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("rows_reached", 32'(rows === want), 32'd1);
    endtask

    // After a release at a negedge, key_held must stay high 102 cycles and drop on the 103rd.
    task automatic check_release(input string tag);
        repeat (102) @(negedge clk);
        check({tag, "_held_late"}, 32'(key_held), 32'd1);
        @(negedge clk);
        check({tag, "_held_drop"}, 32'(key_held), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_rows;
        time        t0;
        int         lat;
        int         k, r, c1, c2;

        reset    = 1'b0;
        key_down = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rows", 32'(rows), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);

        // Scan walk with no keys: 4 cycles per row, wrapping after row 3
        reset = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            exp_rows = ~(4'b0001 << ((i / 4) % 4));
            check("scan_walk", 32'(rows), 32'(exp_rows));
            @(negedge clk);
        end

        // Clean press of '5'
        pulse_cnt = 0;
        key_down[5] = 1'b1;
        t0 = $time;
        repeat (150) @(negedge clk);
        lat = int'((pulse_time - t0) / 10);
        check("k5_pulses", 32'(pulse_cnt), 32'd1);
        check("k5_code", 32'(last_code), 32'h5);
        check("k5_latency", 32'(lat >= 100 && lat <= 125), 32'd1);
        check("k5_held", 32'(key_held), 32'd1);
        key_down[5] = 1'b0;
        check_release("k5");
        check("k5_pulses_end", 32'(pulse_cnt), 32'd1);

        // Bouncy '9' while row 2 is driven
        pulse_cnt = 0;
        wait_rows(4'b1011, 40);
        for (int i = 0; i < 5; i++) begin
            key_down[10] = ~key_down[10];
            if (i < 4) #15;
        end
        t0 = $time;
        @(negedge clk);
        check("k9_no_bounce_pulse", 32'(pulse_cnt), 32'd0);
        wait_pulse(1, 200);
        check("k9_code", 32'(last_code), 32'h9);
        check("k9_stable_time", 32'((pulse_time - t0) >= 1000), 32'd1);
        repeat (20) @(negedge clk);
        key_down[10] = 1'b0;
        repeat (110) @(negedge clk);
        check("k9_released", 32'(key_held), 32'd0);
        check("k9_pulses", 32'(pulse_cnt), 32'd1);

        // Release bounce while holding 'D'
        pulse_cnt = 0;
        key_down[15] = 1'b1;
        wait_pulse(1, 200);
        check("kd_code", 32'(last_code), 32'hD);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            key_down[15] = 1'b0;
            repeat (10) @(negedge clk);
            key_down[15] = 1'b1;
            repeat (5) @(negedge clk);
        end
        check("kd_held_bounce", 32'(key_held), 32'd1);
        key_down[15] = 1'b0;
        check_release("kd");
        check("kd_pulses", 32'(pulse_cnt), 32'd1);

        // Two keys in row 0, then reset while held
        pulse_cnt = 0;
        key_down[0] = 1'b1;
        key_down[2] = 1'b1;
        wait_pulse(1, 200);
        check("k13_code", 32'(last_code), 32'h1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_held", 32'(key_held), 32'd0);
        check("midrst_rows", 32'(rows), 32'hE);
        check("midrst_code", 32'(key_code), 32'h0);
        key_down = '0;
        @(negedge clk);
        reset = 1'b1;

        // Random single keys
        for (int t = 0; t < 8; t++) begin
            k = int'($urandom_range(15, 0));
            pulse_cnt = 0;
            key_down[k] = 1'b1;
            t0 = $time;
            wait_pulse(1, 200);
            lat = int'((pulse_time - t0) / 10);
            check("rnd_code", 32'(last_code), 32'(legend[k]));
            check("rnd_latency", 32'(lat >= 100 && lat <= 125), 32'd1);
            check("rnd_held", 32'(key_held), 32'd1);
            repeat ($urandom_range(40, 0)) @(negedge clk);
            key_down = '0;
            repeat (110) @(negedge clk);
            check("rnd_released", 32'(key_held), 32'd0);
            check("rnd_pulses", 32'(pulse_cnt), 32'd1);
        end

        // Random same-row pairs: lower column wins
        for (int t = 0; t < 4; t++) begin
            r  = int'($urandom_range(3, 0));
            c1 = int'($urandom_range(3, 0));
            c2 = (c1 + 1 + int'($urandom_range(2, 0))) % 4;
            pulse_cnt = 0;
            key_down[r*4+c1] = 1'b1;
            key_down[r*4+c2] = 1'b1;
            wait_pulse(1, 200);
            check("pair_code", 32'(last_code), 32'(legend[r*4 + ((c1 < c2) ? c1 : c2)]));
            repeat (10) @(negedge clk);
            key_down = '0;
            repeat (110) @(negedge clk);
            check("pair_pulses", 32'(pulse_cnt), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
